// File: rtl/fixed_math_pkg.sv
// Shared fixed-point math types and constants: divider state encoding and
// signed saturation limits for an arbitrary result width.
package fixed_math_pkg;

   typedef enum logic [1:0] {IDLE, DIVIDE, FIX, DONE} fdiv_state_t;

   localparam int unsigned SAT_W = 128;

   // Largest positive two's-complement value of the given width, zero-extended to SAT_W.
   function automatic logic [SAT_W-1:0] sat_max(input int unsigned width);
      logic [SAT_W-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < width - 1; i++) v[i] = 1'b1;
      return v;
   endfunction

   // Most negative two's-complement value of the given width, zero-extended to SAT_W.
   function automatic logic [SAT_W-1:0] sat_min(input int unsigned width);
      logic [SAT_W-1:0] v;
      v = '0;
      v[width-1] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/fixed_divide_seq_udiv_step.sv
// One restoring radix-2 division iteration: shift in a dividend bit and
// conditionally subtract the divisor.
module udiv_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;

   always_comb begin
      trial = {rem_in, bit_in};
      diff  = trial - {1'b0, divisor};
      q_bit = (trial >= {1'b0, divisor});
      // Remainder stays below the divisor, so the top bit is always discarded safely.
      rem_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
   end

endmodule

// File: rtl/fixed_divide_seq.sv
// Sequential signed fixed-point divider c = (a << fractional_size) / b, one quotient bit per clock.
// Define FIXED_DIVIDE_ROUND_EN to round half away from zero instead of truncating.
module fixed_divide_seq
   import fixed_math_pkg::*;
#(
   parameter int unsigned fractional_size = 12,
   parameter int unsigned operand_size    = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [operand_size-1:0]   a,
   input  logic [operand_size-1:0]   b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2*operand_size-1:0] c,
   output logic                      div_by_zero
);

   localparam int unsigned W     = operand_size + fractional_size;
   localparam int unsigned CW    = 2 * operand_size;
   localparam int unsigned CNT_W = $clog2(W);

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_DIVIDE = DIVIDE;
   localparam logic [1:0] ST_FIX    = FIX;
   localparam logic [1:0] ST_DONE   = DONE;

   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(W - 1);
   localparam logic [SAT_W-1:0] SAT_MAX_FULL = sat_max(CW);
   localparam logic [SAT_W-1:0] SAT_MIN_FULL = sat_min(CW);
   localparam logic [CW-1:0]    SAT_MAX      = SAT_MAX_FULL[CW-1:0];
   localparam logic [CW-1:0]    SAT_MIN      = SAT_MIN_FULL[CW-1:0];

   logic [1:0]              state;
   logic                    sign;
   logic                    a_neg;
   logic                    dbz;
   logic [operand_size-1:0] mag_b;
   logic [operand_size-1:0] rem;
   logic [W-1:0]            dividend;
   logic [W-1:0]            quot;
   logic [CNT_W-1:0]        count;

   logic [operand_size-1:0] mag_a_in;
   logic [operand_size-1:0] mag_b_in;
   logic [operand_size-1:0] step_rem;
   logic                    step_q;
   logic [CW-1:0]           mag_q;
   logic [CW-1:0]           fix_val;

   // -2^(N-1) negates to itself, which reads correctly as the unsigned magnitude 2^(N-1).
   assign mag_a_in = a[operand_size-1] ? -a : a;
   assign mag_b_in = b[operand_size-1] ? -b : b;

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);

   udiv_step #(.WIDTH(operand_size)) u_step (
      .rem_in  (rem),
      .bit_in  (dividend[W-1]),
      .divisor (mag_b),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   always_comb begin
      mag_q = CW'(quot);
`ifdef FIXED_DIVIDE_ROUND_EN
      if ({rem, 1'b0} >= {1'b0, mag_b}) mag_q = mag_q + CW'(1);
`endif
      fix_val = sign ? -mag_q : mag_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         sign        <= 1'b0;
         a_neg       <= 1'b0;
         dbz         <= 1'b0;
         mag_b       <= '0;
         rem         <= '0;
         dividend    <= '0;
         quot        <= '0;
         count       <= '0;
         c           <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  sign     <= a[operand_size-1] ^ b[operand_size-1];
                  a_neg    <= a[operand_size-1];
                  mag_b    <= mag_b_in;
                  dividend <= {mag_a_in, {fractional_size{1'b0}}};
                  rem      <= '0;
                  quot     <= '0;
                  count    <= CNT_LAST;
                  dbz      <= (b == '0);
                  state    <= (b == '0) ? ST_FIX : ST_DIVIDE;
               end
            end
            ST_DIVIDE: begin
               rem      <= step_rem;
               dividend <= {dividend[W-2:0], 1'b0};
               quot     <= {quot[W-2:0], step_q};
               count    <= count - 1'b1;
               if (count == '0) state <= ST_FIX;
            end
            ST_FIX: begin
               if (dbz) begin
                  c           <= a_neg ? SAT_MIN : SAT_MAX;
                  div_by_zero <= 1'b1;
               end else begin
                  c           <= fix_val;
                  div_by_zero <= 1'b0;
               end
               state <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_divide_seq.sv
// Randomized and directed bench for fixed_divide_seq against an arithmetic reference model.
module tb_fixed_divide_seq;

   localparam int FRAC = 12;
   localparam int OPW  = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [OPW-1:0]  a;
   logic [OPW-1:0]  b;
   logic            out_valid;
   logic            out_ready;
   logic [2*OPW-1:0] c;
   logic            div_by_zero;

   int checks = 0;
   int errors = 0;

   fixed_divide_seq #(.fractional_size(FRAC), .operand_size(OPW)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .c           (c),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: plain integer division of the scaled magnitudes, sign applied afterwards.
   function automatic logic [63:0] model_c(input logic [31:0] ma_in, input logic [31:0] mb_in,
                                           output logic dbz);
      longint sa, sb, ma, mb, num, q, r;
      sa = longint'($signed(ma_in));
      sb = longint'($signed(mb_in));
      if (sb == 0) begin
         dbz = 1'b1;
         return (sa < 0) ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
      end
      dbz = 1'b0;
      ma  = (sa < 0) ? -sa : sa;
      mb  = (sb < 0) ? -sb : sb;
      num = ma * (64'sd1 << FRAC);
      q   = num / mb;
      r   = num % mb;
`ifdef FIXED_DIVIDE_ROUND_EN
      if (2 * r >= mb) q = q + 1;
`endif
      return ((sa < 0) != (sb < 0)) ? 64'(-q) : 64'(q);
   endfunction

   // Present one operand pair, wait for the result; lat counts cycles including the accept cycle.
   task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (!in_ready) check("wait_in_ready", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1;
      a = av;
      b = bv;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
      if (!out_valid) check("wait_out_valid", {63'd0, out_valid}, 64'd1);
   endtask

   task automatic release_result(input int delay);
      for (int i = 0; i < delay; i++) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("ready_after_pop", {63'd0, in_ready}, 64'd1);
      check("valid_after_pop", {63'd0, out_valid}, 64'd0);
   endtask

   task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv, input int delay);
      logic [63:0] exp;
      logic        exp_dbz;
      int          lat;
      exp = model_c(av, bv, exp_dbz);
      start_op(av, bv);
      wait_result(lat);
      check({tag, "_c"}, c, exp);
      check({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, exp_dbz});
      release_result(delay);
   endtask

   initial begin
      logic [63:0] held_c;
      logic [31:0] ra, rb;
      int          lat;
      int          sel;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_c", c, 64'd0);
      check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1.0 / 2.0 with the latency measured from the accept cycle.
      start_op(32'd4096, 32'd8192);
      wait_result(lat);
      check("half_lat", 64'(lat), 64'd46);
      check("half_c", c, 64'd2048);
      check("half_dbz", {63'd0, div_by_zero}, 64'd0);
      release_result(0);

      run_op("neg_a", 32'($signed(-12288)), 32'd6144, 0);
      run_op("neg_b", 32'd12288, 32'($signed(-6144)), 1);
      check("neg_b_exact", c, 64'hFFFF_FFFF_FFFF_E000);
      run_op("dbz_pos", 32'd4096, 32'd0, 0);
      check("dbz_pos_exact", c, 64'h7FFF_FFFF_FFFF_FFFF);
      run_op("dbz_neg", 32'($signed(-4096)), 32'd0, 2);
      check("dbz_neg_exact", c, 64'h8000_0000_0000_0000);
      run_op("round_pos", 32'd1, 32'd8192, 0);
      run_op("round_neg", 32'($signed(-1)), 32'd8192, 0);
      run_op("zero_a", 32'd0, 32'($signed(-5)), 0);
      run_op("min_a", 32'h8000_0000, 32'd1, 0);

      // Backpressure: result held, new requests ignored.
      start_op(32'd40960, 32'd3000);
      wait_result(lat);
      held_c = c;
      check("hold_c_ref", c, model_c(32'd40960, 32'd3000, sel[0]));
      in_valid = 1'b1; a = 32'd7; b = 32'd9;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("hold_c", c, held_c);
         check("hold_valid", {63'd0, out_valid}, 64'd1);
         check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      in_valid = 1'b0;
      release_result(0);
      @(posedge clk); #1;
      check("hold_not_accepted", {63'd0, in_ready}, 64'd1);

      // Reset partway through the iterations.
      start_op(32'd123456, 32'd789);
      repeat (19) @(posedge clk);
      #1;
      check("mid_busy", {63'd0, in_ready}, 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("mid_rst_c", c, 64'd0);
      run_op("after_rst", 32'd8192, 32'd4096, 0);
      check("after_rst_exact", c, 64'd8192);

      for (int i = 0; i < 40; i++) begin
         sel = int'($urandom_range(0, 9));
         ra  = $urandom;
         rb  = $urandom;
         if (sel < 4) begin
            ra = 32'($signed(ra[19:0]));
            rb = 32'($signed(rb[15:0]));
         end else if (sel == 4) begin
            rb = '0;
         end else if (sel == 5) begin
            ra = 32'h8000_0000;
         end else if (sel == 6) begin
            rb = 32'($signed(rb[3:0]));
         end
         run_op("rand", ra, rb, int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
